fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 125_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 The block SHALL have parameter WIDTH, default 8, data bits per frame (1..16).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable  input  1  permits starting new frames.
REQ-007 The block SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO read side.
REQ-008 The block SHALL have port fifo_dout  input  WIDTH  upstream FIFO read data, registered, valid the cycle after a read strobe.
REQ-009 The block SHALL have port fifo_rd_en  output  1  single-cycle read strobe to the upstream FIFO.
REQ-010 The block SHALL have port serial_out  output  1  UART line, idle high.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port frames_sent  output  16  count of completed frames.

Function
REQ-013 CLKS_PER_BIT SHALL equal CLOCK_FREQ/BAUD_RATE (integer division); every line bit is held exactly CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, FETCH, SEND; encoding is free.
REQ-015 fifo_rd_en SHALL be combinational: high only when state==IDLE && enable && !fifo_empty.
REQ-016 IDLE -> FETCH SHALL occur on the edge ending a cycle with fifo_rd_en high; otherwise IDLE holds with serial_out=1.
REQ-017 In FETCH (exactly one cycle) fifo_dout SHALL be captured into the shift register at the closing edge, serial_out driven 0 (start bit), and state -> SEND.
REQ-018 SEND SHALL emit start bit, WIDTH data bits LSB first, [parity bit per REQ-027], then one stop bit (1).
REQ-019 Frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles, +CLKS_PER_BIT with parity; stop bit is held for its full duration before leaving SEND.
REQ-020 At the end of the stop bit, SEND -> IDLE and frames_sent SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-021 Back-to-back frames: IDLE SHALL last exactly one cycle (the rd_en cycle) and FETCH one cycle, so the inter-frame idle-high gap is exactly 1 cycle beyond the stop bit.
REQ-022 fifo_empty and enable SHALL be sampled only in IDLE; deasserting enable or FIFO going empty mid-frame SHALL NOT truncate the frame.
REQ-023 fifo_rd_en SHALL never be high in FETCH or SEND; at most one read per frame; no read while fifo_empty=1.
REQ-024 The bit-period counter and bit index SHALL be internal, sized by $clog2, and reset at the start of each bit/frame respectively.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, serial_out=1, busy=0, fifo_rd_en=0, frames_sent=0, counters and shift register to 0, including mid-frame (frame abandoned, not counted).
REQ-026 After rst_n rises, the first fifo_rd_en SHALL occur no earlier than the first full clock cycle with rst_n high.

Configuration
REQ-027 With macro FIFO_UART_TX_PARITY_EN defined, an even parity bit (XOR of data bits) SHALL be sent between last data bit and stop bit; undefined, no parity bit exists and no parity logic is synthesised.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, WIDTH=8 -> 10 clks/bit)
REQ-028 FIFO holds 0xA5, enable=1 -> one rd_en pulse; serial_out 0,1,0,1,0,0,1,0,1,1 each 10 cycles; frames_sent=1; busy low after 100+1 cycles.
REQ-029 FIFO holds 0x01,0xFF,0x00 -> three consecutive frames, each 100 cycles, 1-cycle idle gaps, exactly three rd_en pulses, frames_sent=3.
REQ-030 fifo_empty=1, enable=1 for 500 cycles -> fifo_rd_en never asserted, serial_out=1, busy=0.
REQ-031 enable dropped at cycle 30 of a 0x3C frame with FIFO non-empty -> frame completes intact, no further rd_en.
REQ-032 rst_n pulsed low at cycle 45 of a frame -> serial_out=1 and busy=0 immediately (before next clock edge), frames_sent=0.
REQ-033 With FIFO_UART_TX_PARITY_EN: 0xA5 -> parity bit 0, 0x07 -> parity bit 1, frame 110 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from an upstream FIFO and serialises each one as
// a UART frame (start bit, WIDTH data bits LSB first, optional parity bit,
// one stop bit). One FIFO read per frame. When the next word is already
// waiting, consecutive frames are separated by a single idle-high cycle.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
module fifo_uart_tx #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             serial_out,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Line bit positions: 0 = start, 1..WIDTH = data, then parity (if any), then stop
  localparam int NUM_BITS = WIDTH + 2 + PAR_BITS;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W    = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_END = IDX_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   clk_cnt_reg;
  logic [IDX_W-1:0]   bit_idx_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic               serial_out_reg;
  logic               busy_reg;
  logic [15:0]        frames_sent_reg;
  // Low until the first clock edge after reset release, so a read strobe can
  // never be issued in the partial cycle in which rst_n rises.
  logic               armed_reg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               parity_reg;
`endif

  logic bit_end;

  assign bit_end     = (clk_cnt_reg == CNT_LAST);
  assign fifo_rd_en  = (state_reg == IDLE) && enable && !fifo_empty && armed_reg;
  assign serial_out  = serial_out_reg;
  assign busy        = busy_reg;
  assign frames_sent = frames_sent_reg;

  // Frame sequencer: fetch one word, then clock out every line bit for CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      clk_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      serial_out_reg  <= 1'b1;
      busy_reg        <= 1'b0;
      frames_sent_reg <= '0;
      armed_reg       <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          serial_out_reg <= 1'b1;
          clk_cnt_reg    <= '0;
          bit_idx_reg    <= '0;
          if (fifo_rd_en) begin
            // Start bit goes out in the FETCH cycle itself
            state_reg      <= FETCH;
            serial_out_reg <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end

        FETCH: begin
          state_reg <= SEND;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_reg <= ^fifo_dout;
`endif
          if (bit_end) begin
            // Single-cycle bit period: the start bit ends here, go straight to data bit 0
            clk_cnt_reg    <= '0;
            bit_idx_reg    <= IDX_W'(1);
            serial_out_reg <= fifo_dout[0];
            shift_reg      <= fifo_dout >> 1;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
            shift_reg   <= fifo_dout;
          end
        end

        SEND: begin
          if (bit_end) begin
            clk_cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              // Stop bit fully held: frame complete
              state_reg       <= IDLE;
              serial_out_reg  <= 1'b1;
              busy_reg        <= 1'b0;
              bit_idx_reg     <= '0;
              frames_sent_reg <= frames_sent_reg + 16'd1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              if (bit_idx_reg < IDX_DATA_END) begin
                serial_out_reg <= shift_reg[0];
                shift_reg      <= shift_reg >> 1;
              end
`ifdef FIFO_UART_TX_PARITY_EN
              else if (bit_idx_reg == IDX_DATA_END) begin
                serial_out_reg <= parity_reg;
              end
`endif
              else begin
                serial_out_reg <= 1'b1;
              end
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg      <= IDLE;
          serial_out_reg <= 1'b1;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx at 10 clocks per bit.
// Words pushed into the modelled FIFO are queued as expected frames; a line
// monitor rebuilds each frame from serial_out and compares it with the
// expected line waveform derived from the UART frame format.
module tb_fifo_uart_tx;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int WIDTH      = 8;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = WIDTH + 3;
`else
  localparam int NB = WIDTH + 2;
`endif
  localparam int FRAME = NB * CPB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rd_en;
  logic             serial_out;
  logic             busy;
  logic [15:0]      frames_sent;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int model_frames = 0;
  int pushes = 0;

  logic [WIDTH-1:0] fifo_mem [256];
  logic [7:0]       wr_ptr = '0;
  logic [7:0]       rd_ptr = '0;
  logic [WIDTH-1:0] exp_q[$];
  int               start_q[$];

  fifo_uart_tx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .WIDTH     (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: registered read data, valid the cycle after the strobe
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Expected line level for line bit b of a frame carrying d
  function automatic logic line_bit(input logic [WIDTH-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= WIDTH) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (b == WIDTH + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
    pushes++;
  endtask

  // Drive point: a little after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rd(output int c, input int budget);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("wait_rd_en");
  endtask

  task automatic wait_cycle(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_empty && busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (done == 0) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: rebuilds each frame and scores it against the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_frames = 0;
      end else if (serial_out === 1'b0) begin : frame_blk
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] rx;
        int bad;
        bit aborted;
        bit have;
        d = '0;
        rx = '0;
        bad = 0;
        aborted = 1'b0;
        start_q.push_back(cyc);
        have = (exp_q.size() != 0);
        if (have) d = exp_q.pop_front();
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (serial_out !== line_bit(d, k / CPB)) bad++;
          if (busy !== 1'b1) bad++;
          if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= WIDTH)
            rx[k / CPB - 1] = serial_out;
        end
        if (aborted) begin
          model_frames = 0;
        end else begin
          check("frame_expected", {31'd0, have}, 32'd1);
          check("frame_line_errs", bad, 0);
          check("frame_data", rx, d);
          $display("frame data=%02h start_cycle=%0d line_errs=%0d", rx, start_q[$], bad);
          model_frames++;
        end
      end
    end
  end

  // Read-strobe monitor
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        rd_cnt++;
        check("rd_en_while_empty", fifo_empty, 1'b0);
        check("rd_en_while_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 300000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t;
    int r0;
    int errs;
    logic [WIDTH-1:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_frames_sent", frames_sent, 16'd0);
    step();
    rst_n = 1'b1;

    // Empty FIFO with enable: line stays idle, no reads
    step();
    enable = 1'b1;
    errs = 0;
    repeat (500) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("empty_idle_500cyc", errs, 0);

    // Single 0xA5 frame, busy drops FRAME+1 cycles after the read strobe
    step();
    r0 = rd_cnt;
    push(8'hA5);
    wait_rd(c0, 50);
    t = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        t = cyc;
        break;
      end
    end
    check("a5_busy_low_delay", t - c0, FRAME + 1);
    @(negedge clk);
    check("a5_rd_pulses", rd_cnt - r0, 1);
    check("a5_frames_sent", frames_sent, 16'd1);

    // Three back-to-back frames with single-cycle gaps
    step();
    start_q.delete();
    r0 = rd_cnt;
    push(8'h01);
    push(8'hFF);
    push(8'h00);
    drain(5 * FRAME);
    check("b2b_rd_pulses", rd_cnt - r0, 3);
    check("b2b_frames_sent", frames_sent, model_frames % 65536);
    check("b2b_frame_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_gap_1_2", start_q[1] - start_q[0], FRAME + 1);
      check("b2b_gap_2_3", start_q[2] - start_q[1], FRAME + 1);
    end

    // Dropping enable mid-frame: frame finishes, the waiting word stays put
    step();
    r0 = rd_cnt;
    push(8'h3C);
    push(8'h55);
    wait_rd(c0, 50);
    wait_cycle(c0 + 30);
    enable = 1'b0;
    repeat (FRAME + 100) @(negedge clk);
    check("en_drop_rd_pulses", rd_cnt - r0, 1);
    check("en_drop_fifo_kept", fifo_empty, 1'b0);
    check("en_drop_frames_sent", frames_sent, model_frames % 65536);
    step();
    enable = 1'b1;
    drain(3 * FRAME);
    check("en_restore_rd_pulses", rd_cnt - r0, 2);

    // Reset asserted mid-frame: outputs return to idle immediately
    step();
    push(8'h96);
    wait_rd(c0, 50);
    wait_cycle(c0 + 45);
    rst_n = 1'b0;
    #1;
    check("midrst_serial_out", serial_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frames_sent", frames_sent, 16'd0);
    check("midrst_rd_en", fifo_rd_en, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    push(8'h3A);
    step();
    rst_n = 1'b1;
    #1;
    check("rd_en_in_release_cycle", fifo_rd_en, 1'b0);
    wait_rd(c0, 10);
    drain(3 * FRAME);
    check("post_rst_frames_sent", frames_sent, 16'd1);

    // Randomised traffic with enable toggling between bursts
    for (int it = 0; it < 16; it++) begin
      step();
      enable = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        d = WIDTH'($urandom);
        push(d);
      end
      repeat ($urandom_range(0, 250)) @(negedge clk);
    end
    step();
    enable = 1'b1;
    drain(60 * (FRAME + 1));
    check("rand_frames_sent", frames_sent, model_frames % 65536);
    check("total_reads_vs_pushes", rd_cnt, pushes);
    check("final_serial_idle", serial_out, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
